// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption round engine.
//   Takes a 128-bit state that has already had the initial AddRoundKey applied,
//   then applies NR rounds, one per accepted round key. Rounds 1..NR-1 do
//   SubBytes, ShiftRows, MixColumns and AddRoundKey; round NR skips MixColumns.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        block start handshake, state on a,b,c,d (row-major)
//   key_req/key_round        request for round key key_round (1..NR)
//   key_valid, q1..q4        round key response (row-major)
//   x,y,z,w                  registered ciphertext (row-major)
//   out_valid/out_ready      ciphertext handshake
//   tap_valid, tap_state     per-round result tap (only with AES_ROUND_TAP_EN)
//
// Build option: define AES_ROUND_TAP_EN to add the tap_valid/tap_state outputs.
//
// FSM states:
//   state | meaning
//   IDLE  | in_ready high, waiting for in_valid
//   ROUND | requesting key_round, one round applied per key_valid cycle
//   DONE  | ciphertext held on x..w until out_ready
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  d,
  output logic         key_req,
  output logic [3:0]   key_round,
  input  logic         key_valid,
  input  logic [31:0]  q1,
  input  logic [31:0]  q2,
  input  logic [31:0]  q3,
  input  logic [31:0]  q4,
  output logic [31:0]  x,
  output logic [31:0]  y,
  output logic [31:0]  z,
  output logic [31:0]  w,
  output logic         out_valid,
  input  logic         out_ready
`ifdef AES_ROUND_TAP_EN
  ,
  output logic         tap_valid,
  output logic [127:0] tap_state
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q;
  logic [127:0] rnd;
  logic [127:0] key;
  logic [3:0]   round_q;
  logic         last_round;
  logic         apply;
  logic [7:0]   sr [4][4];
  logic [7:0]   mc [4][4];

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  assign last_round = (round_q == NR_L);
  assign apply      = (fsm_q == ROUND) && key_valid;
  assign key        = {q1, q2, q3, q4};

  // State layout is {row0,row1,row2,row3}; within a row, column 0 is the MSB.
  // sr[r][col] already combines SubBytes and the left rotation of row r by r.
  always_comb begin
    rnd = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        sr[r][col] = SBOX[st_q[127 - 32*r - 8*((col + r) % 4) -: 8]];
      end
    end
    for (int col = 0; col < 4; col++) begin
      mc[0][col] = xt(sr[0][col]) ^ xt(sr[1][col]) ^ sr[1][col] ^ sr[2][col] ^ sr[3][col];
      mc[1][col] = sr[0][col] ^ xt(sr[1][col]) ^ xt(sr[2][col]) ^ sr[2][col] ^ sr[3][col];
      mc[2][col] = sr[0][col] ^ sr[1][col] ^ xt(sr[2][col]) ^ xt(sr[3][col]) ^ sr[3][col];
      mc[3][col] = xt(sr[0][col]) ^ sr[0][col] ^ sr[1][col] ^ sr[2][col] ^ xt(sr[3][col]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        rnd[127 - 32*r - 8*col -: 8] = ((round_q < NR_L) ? mc[r][col] : sr[r][col])
                                       ^ key[127 - 32*r - 8*col -: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = ROUND;
      ROUND:   if (apply && last_round) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign key_req   = (fsm_q == ROUND);
  assign key_round = key_req ? round_q : 4'd0;
  assign out_valid = (fsm_q == DONE);

  // The round counter stops at NR on the final round and is cleared on the
  // way back to IDLE, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '0;
      round_q <= 4'd0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      w       <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          round_q <= in_valid ? 4'd1 : 4'd0;
          if (in_valid) st_q <= {a, b, c, d};
        end
        ROUND: begin
          if (apply) begin
            st_q <= rnd;
            if (last_round) {x, y, z, w} <= rnd;
            else            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) round_q <= 4'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ROUND_TAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_valid <= 1'b0;
      tap_state <= '0;
    end else begin
      tap_valid <= apply;
      if (apply) tap_state <= rnd;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
module tb_aes_round_engine;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b, c, d;
  logic        key_req, key_valid;
  logic [3:0]  key_round;
  logic [31:0] q1, q2, q3, q4;
  logic [31:0] x, y, z, w;
  logic        out_valid, out_ready;

  logic        iv1, ir1, kr1_req, kv1, ov1, or1;
  logic [3:0]  kr1;
  logic [31:0] a1, b1, c1, d1, p1, p2, p3, p4, x1, y1, z1, w1;

`ifdef AES_ROUND_TAP_EN
  logic         tap_valid, tap_valid1;
  logic [127:0] tap_state, tap_state1;
`endif

  aes_round_engine #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .key_req(key_req), .key_round(key_round), .key_valid(key_valid),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .x(x), .y(y), .z(z), .w(w), .out_valid(out_valid), .out_ready(out_ready)
`ifdef AES_ROUND_TAP_EN
    , .tap_valid(tap_valid), .tap_state(tap_state)
`endif
  );

  aes_round_engine #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .key_req(kr1_req), .key_round(kr1), .key_valid(kv1),
    .q1(p1), .q2(p2), .q3(p3), .q4(p4),
    .x(x1), .y(y1), .z(z1), .w(w1), .out_valid(ov1), .out_ready(or1)
`ifdef AES_ROUND_TAP_EN
    , .tap_valid(tap_valid1), .tap_state(tap_state1)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [15:0]  stall;
    int           lat;
  } vec_t;

  vec_t         tv [4];
  logic [7:0]   sb [256];
  logic [127:0] rk [0:10];

`ifdef AES_ROUND_TAP_EN
  int           tap_total = 0;
  logic [127:0] tap_hist [64];
  always @(negedge clk) begin
    if (tap_valid) begin
      if (tap_total < 64) tap_hist[tap_total] <= tap_state;
      tap_total <= tap_total + 1;
    end
  end
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = p; bb = q;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from the field inverse and affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int u = 1; u < 256; u++)
        if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] wd [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
  endtask

  // FIPS byte order (column-major) to one row of the row-major ports.
  function automatic logic [31:0] row_of(input logic [127:0] blk, input int r);
    return {blk[127 - 8*r -: 8], blk[127 - 8*(r+4) -: 8],
            blk[127 - 8*(r+8) -: 8], blk[127 - 8*(r+12) -: 8]};
  endfunction

  function automatic logic [127:0] rows(input logic [127:0] blk);
    return {row_of(blk, 0), row_of(blk, 1), row_of(blk, 2), row_of(blk, 3)};
  endfunction

  task automatic set_key();
    int idx;
    idx = int'(key_round);
    if (idx >= 1 && idx <= 10) {q1, q2, q3, q4} = rows(rk[idx]);
    else                       {q1, q2, q3, q4} = '0;
  endtask

  task automatic chk_ct(input string nm, input logic [127:0] ct);
    chk({nm, ".x"}, {96'h0, x}, {96'h0, row_of(ct, 0)});
    chk({nm, ".y"}, {96'h0, y}, {96'h0, row_of(ct, 1)});
    chk({nm, ".z"}, {96'h0, z}, {96'h0, row_of(ct, 2)});
    chk({nm, ".w"}, {96'h0, w}, {96'h0, row_of(ct, 3)});
  endtask

  // Leaves in_valid high; returns #1 after the accepting edge.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
    bit ok;
    ok = 0;
    expand(key);
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) timeout("start_in_ready");
    {a, b, c, d} = rows(pt ^ key);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("accept_in_ready", {127'h0, in_ready}, 128'h0);
  endtask

  // Supplies round keys, stalling once at each round set in stall_mask.
  // Returns at the negedge where out_valid is seen; lat counts edges since accept.
  task automatic drive_rounds(input logic [15:0] stall_mask, output int lat);
    int          n;
    bit          done;
    logic [3:0]  exp_kr;
    logic [15:0] used;
    n = 0; done = 0; exp_kr = 4'd1; used = '0;
    while (n < 64 && !done) begin
      @(negedge clk);
      if (out_valid) done = 1;
      else begin
        chk("key_req", {127'h0, key_req}, 128'h1);
        chk("key_round", {124'h0, key_round}, {124'h0, exp_kr});
        if (stall_mask[exp_kr] && !used[exp_kr]) begin
          used[exp_kr] = 1'b1;
          key_valid = 1'b0;
        end else begin
          key_valid = 1'b1;
          exp_kr = exp_kr + 4'd1;
        end
        set_key();
        @(posedge clk);
        n++;
      end
    end
    if (!done) timeout("out_valid");
    key_valid = 1'b0;
    lat = n;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", {127'h0, out_valid}, 128'h0);
    chk("drain_in_ready", {127'h0, in_ready}, 128'h1);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".out_valid"}, {127'h0, out_valid}, 128'h0);
    chk({nm, ".key_req"}, {127'h0, key_req}, 128'h0);
    chk({nm, ".key_round"}, {124'h0, key_round}, 128'h0);
    chk({nm, ".in_ready"}, {127'h0, in_ready}, 128'h1);
    chk({nm, ".xyzw"}, {x, y, z, w}, 128'h0);
  endtask

  initial begin
    int lat;
`ifdef AES_ROUND_TAP_EN
    int base;
`endif
    rst = 1'b1; in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b0;
    {a, b, c, d} = '0; {q1, q2, q3, q4} = '0;
    iv1 = 1'b0; kv1 = 1'b0; or1 = 1'b0;
    {a1, b1, c1, d1} = '0; {p1, p2, p3, p4} = '0;

    tv[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16'h0000, 10};
    tv[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32, 16'h0000, 10};
    tv[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 16'h0000, 10};
    // Same FIPS block with one key stall in each of rounds 2, 5 and 10.
    tv[3] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16'h0424, 13};

    build_sbox();

    #1;
    chk_reset_outputs("reset");
    chk("reset.dut1_out_valid", {127'h0, ov1}, 128'h0);
`ifdef AES_ROUND_TAP_EN
    chk("reset.tap_valid", {127'h0, tap_valid}, 128'h0);
    chk("reset.tap_state", tap_state, 128'h0);
`endif
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
`ifdef AES_ROUND_TAP_EN
      base = tap_total;
`endif
      start_block(tv[i].pt, tv[i].key);
      in_valid = 1'b0;
      drive_rounds(tv[i].stall, lat);
      chk($sformatf("vec%0d.latency", i), 128'(lat), 128'(tv[i].lat));
      chk_ct($sformatf("vec%0d", i), tv[i].ct);
`ifdef AES_ROUND_TAP_EN
      if (i == 0) begin
        @(posedge clk); #1;
        chk("tap.count", 128'(tap_total - base), 128'd10);
        chk("tap.first", tap_hist[base], 128'h89852dcb_d85a1812_10ce438f_e868d8e4);
        @(negedge clk);
      end
`endif
      drain();
    end

    // Output backpressure with a second block waiting on in_valid.
    start_block(tv[0].pt, tv[0].key);
    {a, b, c, d} = rows(tv[1].pt ^ tv[1].key);
    drive_rounds(16'h0000, lat);
    chk("bp.latency", 128'(lat), 128'd10);
    for (int k = 0; k < 5; k++) begin
      chk("bp.xyzw", {x, y, z, w}, 128'h696ad870_c47bcdb4_e004b7c5_d830805a);
      chk("bp.in_ready", {127'h0, in_ready}, 128'h0);
      chk("bp.out_valid", {127'h0, out_valid}, 128'h1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.released_out_valid", {127'h0, out_valid}, 128'h0);
    chk("bp.released_in_ready", {127'h0, in_ready}, 128'h1);
    expand(tv[1].key);
    @(posedge clk); #1;
    chk("bp.second_accept", {127'h0, key_req}, 128'h1);
    in_valid = 1'b0;
    drive_rounds(16'h0000, lat);
    chk("bp2.latency", 128'(lat), 128'd10);
    chk_ct("bp2", tv[1].ct);
    drain();

    // Reset during round 4.
    start_block(tv[1].pt, tv[1].key);
    in_valid = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge clk);
        if (key_round == 4'd4) hit = 1;
        else begin
          key_valid = 1'b1;
          set_key();
          @(posedge clk);
        end
      end
      if (!hit) timeout("reach_round4");
    end
    key_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    key_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    start_block(tv[0].pt, tv[0].key);
    in_valid = 1'b0;
    drive_rounds(16'h0000, lat);
    chk("postrst.latency", 128'(lat), 128'd10);
    chk_ct("postrst", tv[0].ct);
    drain();

    // NR=1: single final round, no MixColumns.
    @(negedge clk);
    chk("nr1.in_ready", {127'h0, ir1}, 128'h1);
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    chk("nr1.key_req", {127'h0, kr1_req}, 128'h1);
    chk("nr1.key_round", {124'h0, kr1}, 128'h1);
    kv1 = 1'b1;
    @(posedge clk); #1;
    kv1 = 1'b0;
    chk("nr1.out_valid", {127'h0, ov1}, 128'h1);
    chk("nr1.xyzw", {x1, y1, z1, w1}, {4{32'h63636363}});
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    chk("nr1.drain", {127'h0, ov1}, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
